// File: rtl/cim_slice_accum_if.sv
// Beat-in / result-out handshake bundle for cim_slice_accum.
//   master : beat producer and result consumer (drives in_valid, in_data, out_ready)
//   slave  : the accumulator (drives in_ready, out_valid, out_data, out_sat)
interface cim_slice_accum_if #(
    parameter int unsigned SLICES = 4,
    parameter int unsigned ROWS   = 36,
    parameter int unsigned PP_W   = 3,
    parameter int unsigned OUT_W  = 22
);
    logic                              in_valid;
    logic                              in_ready;
    logic [SLICES*ROWS*PP_W-1:0]       in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic signed [OUT_W-1:0]           out_data;
    logic                              out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/cim_slice_accum.sv
// Bit-sliced CIM partial-product accumulator. Each accepted beat carries
// SLICES x ROWS signed products; per-slice row sums are staged, accumulated
// over num_beats beats, then combined with weight 2^(s*SLICE_W) (top slice
// negative when signed_msb) and saturated to OUT_W bits.
// Ports:
//   clk, RSTN            clock, async active-low reset
//   start, num_beats,
//   signed_msb           operation request + configuration (sampled in IDLE)
//   busy                 high whenever not IDLE
//   bus (slave)          in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_sat
module cim_slice_accum #(
    parameter int unsigned ROWS    = 36,
    parameter int unsigned SLICES  = 4,
    parameter int unsigned SLICE_W = 2,
    parameter int unsigned PP_W    = 3,
    parameter int unsigned BEAT_W  = 4,
    parameter int unsigned OUT_W   = 22
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              start,
    input  logic [BEAT_W-1:0] num_beats,
    input  logic              signed_msb,
    output logic              busy,
    cim_slice_accum_if.slave  bus
);

    localparam int unsigned SUM_W  = PP_W + $clog2(ROWS);
    localparam int unsigned ACC_W  = SUM_W + BEAT_W;
    localparam int unsigned COMB_W = ACC_W + (SLICES - 1) * SLICE_W + $clog2(SLICES) + 1;
    localparam int unsigned EXT_W  = (COMB_W > OUT_W) ? COMB_W : OUT_W;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        DRAIN   = 3'd2,
        COMBINE = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [BEAT_W-1:0]       nb_q;
    logic                    sgn_q;
    logic [BEAT_W-1:0]       cnt_q;
    logic                    drain_q;
    logic                    stage_vld_q;
    logic signed [SUM_W-1:0] stage_q [SLICES];
    logic signed [ACC_W-1:0] acc_q   [SLICES];

    logic                     load_c;
    logic                     accept_c;
    logic                     last_c;
    logic                     hs_c;
    logic signed [SUM_W-1:0]  sum_c [SLICES];
    logic signed [COMB_W-1:0] comb_c;
    logic signed [OUT_W-1:0]  sat_c;
    logic                     clip_c;

    // in_ready is only ever high in ACCUM, so it alone qualifies a beat
    assign accept_c = bus.in_ready && bus.in_valid;
    assign last_c   = accept_c && (cnt_q == nb_q - BEAT_W'(1));
    assign hs_c     = bus.out_valid && bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM:   if (last_c)  state_nxt = DRAIN;
            DRAIN:   if (drain_q) state_nxt = COMBINE;
            COMBINE: state_nxt = OUT;
            OUT:     if (hs_c)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered handshake/status outputs and drain timer.
    // out_valid rises one cycle after entering OUT so the result is
    // presented four edges after the last accepted beat.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            drain_q       <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nxt == ACCUM);
            bus.out_valid <= (state == OUT) && !hs_c;
            busy          <= (state_nxt != IDLE);
            drain_q       <= (state == DRAIN) && !drain_q;
        end
    end

    // Latched configuration and beat counter
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            nb_q  <= '0;
            sgn_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_c) begin
            nb_q  <= (num_beats == '0) ? BEAT_W'(1) : num_beats;
            sgn_q <= signed_msb;
            cnt_q <= '0;
        end else if (accept_c) begin
            cnt_q <= cnt_q + BEAT_W'(1);
        end
    end

    // Per-slice sign-extended row sums of the incoming beat
    always_comb begin
        logic signed [PP_W-1:0] pp;
        pp = '0;
        for (int unsigned s = 0; s < SLICES; s++) begin
            sum_c[s] = '0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                pp       = bus.in_data[(s * ROWS + r) * PP_W +: PP_W];
                sum_c[s] = sum_c[s] + SUM_W'(pp);
            end
        end
    end

    // Stage register then accumulator, one cycle apart
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            stage_vld_q <= 1'b0;
            for (int unsigned s = 0; s < SLICES; s++) begin
                stage_q[s] <= '0;
                acc_q[s]   <= '0;
            end
        end else if (load_c) begin
            stage_vld_q <= 1'b0;
            for (int unsigned s = 0; s < SLICES; s++) begin
                stage_q[s] <= '0;
                acc_q[s]   <= '0;
            end
        end else begin
            stage_vld_q <= accept_c;
            for (int unsigned s = 0; s < SLICES; s++) begin
                if (accept_c)    stage_q[s] <= sum_c[s];
                if (stage_vld_q) acc_q[s]   <= acc_q[s] + ACC_W'(stage_q[s]);
            end
        end
    end

    // Full-precision weighted combine and saturation
    always_comb begin
        logic signed [COMB_W-1:0] term;
        logic signed [EXT_W-1:0]  ext;
        comb_c = '0;
        term   = '0;
        for (int unsigned s = 0; s < SLICES; s++) begin
            term = COMB_W'(acc_q[s]);
            term = term <<< (s * SLICE_W);
            if ((s == SLICES - 1) && sgn_q) comb_c = comb_c - term;
            else                            comb_c = comb_c + term;
        end
        ext = EXT_W'(comb_c);
        if (ext > SAT_MAX) begin
            sat_c  = SAT_MAX[OUT_W-1:0];
            clip_c = 1'b1;
        end else if (ext < SAT_MIN) begin
            sat_c  = SAT_MIN[OUT_W-1:0];
            clip_c = 1'b1;
        end else begin
            sat_c  = ext[OUT_W-1:0];
            clip_c = 1'b0;
        end
    end

    // Result register, held until the next COMBINE
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            bus.out_data <= '0;
            bus.out_sat  <= 1'b0;
        end else if (state == COMBINE) begin
            bus.out_data <= sat_c;
            bus.out_sat  <= clip_c;
        end
    end

endmodule

// File: tb/tb_cim_slice_accum.sv
// Bench for cim_slice_accum: a 22-bit and a 12-bit output instance run in
// lockstep on identical stimulus; directed vector table, reset-abort
// sequence and random operations checked against an arithmetic model.
module tb_cim_slice_accum;

    localparam int unsigned ROWS    = 36;
    localparam int unsigned SLICES  = 4;
    localparam int unsigned SLICE_W = 2;
    localparam int unsigned PP_W    = 3;
    localparam int unsigned BEAT_W  = 4;
    localparam int unsigned OUT_W   = 22;
    localparam int unsigned OUT_W_S = 12;
    localparam int unsigned DW      = SLICES * ROWS * PP_W;

    typedef logic [SLICES-1:0][PP_W-1:0] ppv_t;

    typedef struct {
        int     nb;
        bit     sgn;
        ppv_t   pp;
        int     gap;
        int     hold;
        longint e22;
        bit     s22;
        longint e12;
        bit     s12;
    } vec_t;

    logic              clk = 1'b0;
    logic              RSTN = 1'b1;
    logic              start = 1'b0;
    logic [BEAT_W-1:0] num_beats = '0;
    logic              signed_msb = 1'b0;
    logic              busy, busy_s;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] beats_q[$];
    vec_t          tbl[8];

    cim_slice_accum_if #(.SLICES(SLICES), .ROWS(ROWS), .PP_W(PP_W), .OUT_W(OUT_W))   bus();
    cim_slice_accum_if #(.SLICES(SLICES), .ROWS(ROWS), .PP_W(PP_W), .OUT_W(OUT_W_S)) bus_s();

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_data   = bus.in_data;
    assign bus_s.out_ready = bus.out_ready;

    cim_slice_accum #(.ROWS(ROWS), .SLICES(SLICES), .SLICE_W(SLICE_W), .PP_W(PP_W),
                      .BEAT_W(BEAT_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .RSTN(RSTN), .start(start), .num_beats(num_beats),
        .signed_msb(signed_msb), .busy(busy), .bus(bus)
    );

    cim_slice_accum #(.ROWS(ROWS), .SLICES(SLICES), .SLICE_W(SLICE_W), .PP_W(PP_W),
                      .BEAT_W(BEAT_W), .OUT_W(OUT_W_S)) dut_s (
        .clk(clk), .RSTN(RSTN), .start(start), .num_beats(num_beats),
        .signed_msb(signed_msb), .busy(busy_s), .bus(bus_s)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic ppv_t pv(input int p3, input int p2, input int p1, input int p0);
        ppv_t v;
        v[3] = PP_W'(p3);
        v[2] = PP_W'(p2);
        v[1] = PP_W'(p1);
        v[0] = PP_W'(p0);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Reference: every product times its slice weight, top slice negative if signed
    function automatic longint model_full(input bit sgn);
        longint tot;
        longint w;
        logic signed [PP_W-1:0] pp;
        tot = 0;
        foreach (beats_q[b]) begin
            for (int s = 0; s < SLICES; s++) begin
                w = longint'(1) << (s * SLICE_W);
                if (s == SLICES - 1 && sgn) w = -w;
                for (int r = 0; r < ROWS; r++) begin
                    pp  = beats_q[b][(s * ROWS + r) * PP_W +: PP_W];
                    tot = tot + longint'(pp) * w;
                end
            end
        end
        return tot;
    endfunction

    function automatic longint clip(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic fill_const(input int nb, input ppv_t pp);
        logic [DW-1:0] d;
        int nbe;
        nbe = (nb == 0) ? 1 : nb;
        beats_q.delete();
        for (int b = 0; b < nbe; b++) begin
            d = '0;
            for (int s = 0; s < SLICES; s++)
                for (int r = 0; r < ROWS; r++)
                    d[(s * ROWS + r) * PP_W +: PP_W] = pp[s];
            beats_q.push_back(d);
        end
    endtask

    // Pulse start with garbage on in_valid (IDLE must ignore it), then scramble config
    task automatic do_start(input int nb, input bit sgn);
        @(negedge clk);
        start        = 1'b1;
        num_beats    = BEAT_W'(nb);
        signed_msb   = sgn;
        bus.in_valid = 1'b1;
        bus.in_data  = rand_vec();
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        num_beats    = BEAT_W'($urandom_range(0, 15));
        signed_msb   = 1'($urandom_range(0, 1));
    endtask

    // Present the first nsend queued beats; returns at the negedge after the last accept
    task automatic send_beats(input int nsend, input int gmin, input int gmax, output bit ok);
        int g, n;
        ok = 1'b1;
        for (int b = 0; b < nsend; b++) begin
            g = $urandom_range(gmin, gmax);
            repeat (g) begin
                bus.in_valid  = 1'b0;
                bus.in_data   = rand_vec();
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = beats_q[b];
            bus.out_ready = 1'($urandom_range(0, 1));
            n = 0;
            while (!bus.in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                chk("beat_accept_timeout", 1, 0);
                ok = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string nm, input int nb, input bit sgn, input int gmin,
                          input int gmax, input int hold, input longint e22, input bit s22,
                          input longint e12, input bit s12);
        bit ok;
        int early, bad, n;
        do_start(nb, sgn);
        send_beats(beats_q.size(), gmin, gmax, ok);
        if (!ok) return;
        bus.out_ready = 1'b0;
        chk({nm, " in_ready_after_last"}, bus.in_ready, 0);
        // in_valid stays high with junk while in_ready is low
        early = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.out_valid || bus_s.out_valid) early++;
            bus.in_valid = 1'b1;
            bus.in_data  = rand_vec();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk({nm, " out_valid_early"}, early, 0);
        chk({nm, " out_valid_at_T4"}, bus.out_valid, 1);
        chk({nm, " out_valid_s_at_T4"}, bus_s.out_valid, 1);
        chk({nm, " data22"}, longint'(bus.out_data), e22);
        chk({nm, " sat22"}, bus.out_sat, longint'(s22));
        chk({nm, " data12"}, longint'(bus_s.out_data), e12);
        chk({nm, " sat12"}, bus_s.out_sat, longint'(s12));
        // Consumer stalls while start is toggled
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            start = ((i % 2) == 0);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || longint'(bus.out_data) != e22 ||
                longint'(bus_s.out_data) != e12 || bus.in_ready || !busy) bad++;
        end
        if (hold > 0) chk({nm, " hold_stable"}, bad, 0);
        // Handshake with start asserted on the same edge
        bus.out_ready = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        bus.out_ready = 1'b0;
        chk({nm, " out_valid_after_hs"}, bus.out_valid || bus_s.out_valid, 0);
        chk({nm, " idle_after_hs"}, busy || busy_s, 0);
        n = 0;
        repeat (2) begin
            @(negedge clk);
            if (busy || bus.out_valid || longint'(bus.out_data) != e22) n++;
        end
        chk({nm, " result_held"}, n, 0);
    endtask

    initial begin
        longint e;
        int nb, nbe;
        bit sgn;
        bit ok;
        int bad;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{1,  1'b0, pv( 1,  1,  1,  1), 0, 5,  3060,   1'b0,  2047, 1'b1};
        tbl[1] = '{1,  1'b1, pv( 1,  1,  1,  1), 0, 1, -1548,   1'b0, -1548, 1'b0};
        tbl[2] = '{3,  1'b0, pv( 0,  0,  0,  3), 2, 0,   324,   1'b0,   324, 1'b0};
        tbl[3] = '{1,  1'b0, pv(-4, -4, -4, -4), 0, 2, -12240,  1'b0, -2048, 1'b1};
        tbl[4] = '{0,  1'b0, pv( 0,  0,  0,  1), 1, 0,    36,   1'b0,    36, 1'b0};
        tbl[5] = '{15, 1'b0, pv( 3,  3,  3,  3), 0, 0, 137700,  1'b0,  2047, 1'b1};
        tbl[6] = '{15, 1'b1, pv( 3, -4, -4, -4), 0, 1, -149040, 1'b0, -2048, 1'b1};
        tbl[7] = '{2,  1'b1, pv(-4,  0,  0,  0), 1, 0, 18432,   1'b0,  2047, 1'b1};

        // Power-on reset
        #2 RSTN = 1'b0;
        #1;
        chk("reset in_ready", bus.in_ready | bus_s.in_ready, 0);
        chk("reset out_valid", bus.out_valid | bus_s.out_valid, 0);
        chk("reset out_data", longint'(bus.out_data), 0);
        chk("reset out_sat", bus.out_sat | bus_s.out_sat, 0);
        chk("reset busy", busy | busy_s, 0);
        repeat (2) @(negedge clk);
        RSTN = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            fill_const(tbl[i].nb, tbl[i].pp);
            run_op($sformatf("vec%0d", i), tbl[i].nb, tbl[i].sgn, tbl[i].gap, tbl[i].gap,
                   tbl[i].hold, tbl[i].e22, tbl[i].s22, tbl[i].e12, tbl[i].s12);
        end

        // Reset mid-operation after 1 of 3 beats
        fill_const(3, pv(3, 3, 3, 3));
        do_start(3, 1'b0);
        send_beats(1, 0, 0, ok);
        #2 RSTN = 1'b0;
        #1;
        chk("midrst in_ready", bus.in_ready | bus_s.in_ready, 0);
        chk("midrst out_valid", bus.out_valid | bus_s.out_valid, 0);
        chk("midrst out_data", longint'(bus.out_data), 0);
        chk("midrst out_data_s", longint'(bus_s.out_data), 0);
        chk("midrst out_sat", bus.out_sat | bus_s.out_sat, 0);
        chk("midrst busy", busy | busy_s, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RSTN = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = rand_vec();
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.out_valid || bus_s.out_valid || busy || bus.in_ready) bad++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("post_reset quiet", bad, 0);
        fill_const(tbl[0].nb, tbl[0].pp);
        run_op("after_reset", tbl[0].nb, tbl[0].sgn, 0, 0, 0,
               tbl[0].e22, tbl[0].s22, tbl[0].e12, tbl[0].s12);

        // Random operations against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            nb  = $urandom_range(0, 15);
            sgn = 1'($urandom_range(0, 1));
            nbe = (nb == 0) ? 1 : nb;
            beats_q.delete();
            for (int b = 0; b < nbe; b++) beats_q.push_back(rand_vec());
            e = model_full(sgn);
            run_op($sformatf("rand%0d", i), nb, sgn, 0, 3, $urandom_range(0, 3),
                   clip(e, OUT_W), clip(e, OUT_W) != e,
                   clip(e, OUT_W_S), clip(e, OUT_W_S) != e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cim_slice_accum.md
CIM_SLICE_ACCUM -- requirements
Module: cim_slice_accum

Interface
REQ-001 The block SHALL have parameter ROWS, 36, number of CIM rows summed per beat.
REQ-002 The block SHALL have parameter SLICES, 4, number of bit-slice channels.
REQ-003 The block SHALL have parameter SLICE_W, 2, bit weight step between adjacent slices.
REQ-004 The block SHALL have parameter PP_W, 3, width of each signed two's-complement row partial product.
REQ-005 The block SHALL have parameter BEAT_W, 4, width of the beat-count configuration.
REQ-006 The block SHALL have parameter OUT_W, 22, width of the signed saturated result.
REQ-007 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1, operation start pulse, sampled only in IDLE.
REQ-010 The block SHALL have port num_beats, input, BEAT_W, beats per operation, latched on start.
REQ-011 The block SHALL have port signed_msb, input, 1, 1 = top slice carries negative weight, latched on start.
REQ-012 The block SHALL have port in_valid, input, 1, beat data valid.
REQ-013 The block SHALL have port in_ready, output, 1, block accepts a beat.
REQ-014 The block SHALL have port in_data, input, SLICES*ROWS*PP_W, packed products; element [s][r] at bit offset (s*ROWS+r)*PP_W.
REQ-015 The block SHALL have port out_valid, output, 1, result valid.
REQ-016 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-017 The block SHALL have port out_data, output, OUT_W, signed combined result.
REQ-018 The block SHALL have port out_sat, output, 1, result was clipped.
REQ-019 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ACCUM, DRAIN, COMBINE, OUT.
REQ-021 IDLE: in_ready=0; on start=1, latch num_beats (0 treated as 1) and signed_msb, clear all slice accumulators and the beat counter, go to ACCUM.
REQ-022 Start outside IDLE, including the cycle of the OUT handshake, SHALL be ignored.
REQ-023 ACCUM: in_ready=1; a beat is accepted only when in_valid and in_ready are both 1; in_valid while in_ready=0 is ignored.
REQ-024 For each accepted beat the block SHALL sign-extend and sum the ROWS products per slice, and register the sums in a stage register one cycle later.
REQ-025 The stage sums SHALL be added into per-slice signed accumulators of width PP_W+clog2(ROWS)+BEAT_W in the following cycle, with no overflow possible.
REQ-026 On acceptance of beat number num_beats the FSM SHALL go to DRAIN, and in_ready SHALL be 0 from the next cycle.
REQ-027 DRAIN SHALL last exactly 2 cycles, then go to COMBINE.
REQ-028 COMBINE SHALL compute, at full precision, sum over s of acc[s] shifted left by s*SLICE_W; the top slice term is negated when latched signed_msb=1.
REQ-029 COMBINE SHALL register the result saturated to the OUT_W signed range into out_data and set out_sat=1 iff clipping occurred, then go to OUT.
REQ-030 Latency: with the last beat accepted on edge T, out_valid SHALL first be 1 after edge T+4.
REQ-031 OUT: out_valid=1; out_data and out_sat SHALL stay stable until out_ready=1; on that edge go to IDLE with out_valid=0 next cycle.
REQ-032 out_ready while out_valid=0 SHALL have no effect.
REQ-033 out_data and out_sat SHALL hold their last value after the handshake until the next COMBINE.

Reset
REQ-034 RSTN=0 SHALL immediately, without a clock, force state IDLE and clear all accumulators, stage registers, the counter and latched configuration, and drive in_ready, out_valid, out_data, out_sat and busy to 0.
REQ-035 Reset in any state SHALL abort the operation with no out_valid pulse; the first operation after release SHALL be unaffected by pre-reset data.

Verification
REQ-036 Verification SHALL cover: num_beats=1, signed_msb=0, all products=1 -> out_data=3060, out_sat=0, out_valid high after edge T+4.
REQ-037 Verification SHALL cover: same stimulus with signed_msb=1 -> out_data=-1548.
REQ-038 Verification SHALL cover: num_beats=3, slice0 products=3, other slices=0, in_valid gapped -> out_data=324; in_ready=0 from the cycle after the third accept.
REQ-039 Verification SHALL cover: OUT_W=12 with stimulus of REQ-036 -> out_data=2047, out_sat=1; all products=-4, signed_msb=0 -> out_data=-2048, out_sat=1.
REQ-040 Verification SHALL cover: out_ready=0 for 5 cycles in OUT with start pulsed -> out_data stable, in_ready=0, start ignored, IDLE after the handshake.
REQ-041 Verification SHALL cover: RSTN=0 after 1 of 3 beats -> all outputs 0 immediately; a fresh REQ-036 operation -> 3060.
